// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that shares one aes_core between NUM_REQ requesters.
// Optional RUN watchdog is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*256-1:0] req_key_i,
    input  logic [NUM_REQ*128-1:0] req_data_i,
    input  logic [NUM_REQ*2-1:0]   req_size_i,
    input  logic [NUM_REQ-1:0]     req_dec_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [127:0]           data_o,
    output logic                   err_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   busy_o,
    output logic                   core_load_o,
    output logic [255:0]           core_key_o,
    output logic [127:0]           core_data_o,
    output logic [1:0]             core_size_o,
    output logic                   core_dec_o,
    input  logic [127:0]           core_data_i,
    input  logic                   core_busy_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [IDX_W-1:0]     grant_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [127:0]         data_q;
    logic                 busy_q;
    logic                 load_q;
    logic [255:0]         key_q;
    logic [127:0]         blk_q;
    logic [1:0]           size_q;
    logic                 dec_q;

    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 win_vld;

    // Scan from the highest offset down so the first set bit at/after ptr_q wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign ptr_d = IDX_W'((int'(win_idx) + 1) % NUM_REQ);

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_q;
    logic             err_q;
    logic             tmo_hit;

    // Counter holds RUN cycles already spent; the hit fires on the TIMEOUT_CYC-th cycle.
    assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            load_q  <= 1'b0;
            key_q   <= '0;
            blk_q   <= '0;
            size_q  <= '0;
            dec_q   <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            load_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        key_q            <= req_key_i[win_idx*256 +: 256];
                        blk_q            <= req_data_i[win_idx*128 +: 128];
                        size_q           <= req_size_i[win_idx*2 +: 2];
                        dec_q            <= req_dec_i[win_idx];
                        grant_q          <= win_idx;
                        ack_q[win_idx]   <= 1'b1;
                        load_q           <= 1'b1;
                        ptr_q            <= ptr_d;
                        busy_q           <= 1'b1;
                        state_q          <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_ARM;
                S_ARM: begin
                    // The core raises busy during this cycle, so it is not sampled yet.
                    state_q <= S_RUN;
`ifdef AES_ARB_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                S_RUN: begin
                    if (!core_busy_i) begin
                        data_q          <= core_data_i;
                        done_q[grant_q] <= 1'b1;
                        state_q         <= S_DONE;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        data_q          <= '0;
                        err_q           <= 1'b1;
                        done_q[grant_q] <= 1'b1;
                        state_q         <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign done_o      = done_q;
    assign data_o      = data_q;
    assign grant_idx_o = grant_q;
    assign busy_o      = busy_q;
    assign core_load_o = load_q;
    assign core_key_o  = key_q;
    assign core_data_o = blk_q;
    assign core_size_o = size_q;
    assign core_dec_o  = dec_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter with a behavioural aes_core stand-in and a transaction scoreboard.
// Build with AES_ARB_TIMEOUT_EN defined to also exercise the watchdog path.
module tb_aes_core_arbiter;
    localparam int N = 4;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_i = '0;
    logic [N*256-1:0] req_key_i = '0;
    logic [N*128-1:0] req_data_i = '0;
    logic [N*2-1:0]   req_size_i = '0;
    logic [N-1:0]     req_dec_i = '0;
    logic [N-1:0]     ack_o, done_o;
    logic [127:0]     data_o;
    logic             err_o;
    logic [1:0]       grant_idx_o;
    logic             busy_o, core_load_o, core_dec_o;
    logic [255:0]     core_key_o;
    logic [127:0]     core_data_o, core_data_i;
    logic [1:0]       core_size_o;
    logic             core_busy_i;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NUM_REQ(N), .IDX_W(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_key_i(req_key_i),
        .req_data_i(req_data_i), .req_size_i(req_size_i), .req_dec_i(req_dec_i),
        .ack_o(ack_o), .done_o(done_o), .data_o(data_o), .err_o(err_o),
        .grant_idx_o(grant_idx_o), .busy_o(busy_o), .core_load_o(core_load_o),
        .core_key_o(core_key_o), .core_data_o(core_data_o), .core_size_o(core_size_o),
        .core_dec_o(core_dec_o), .core_data_i(core_data_i), .core_busy_i(core_busy_i)
    );

    // Known-answer AES-128 pair, otherwise a cheap reversible mix of the operands.
    function automatic logic [127:0] model(input logic [255:0] k, input logic [127:0] d,
                                           input logic [1:0] s, input logic dec);
        if (s == 2'd0 && k[255:128] == K128 && !dec && d == PT) return CT;
        if (s == 2'd0 && k[255:128] == K128 && dec && d == CT) return PT;
        return d ^ k[127:0] ^ k[255:128] ^ {125'd0, dec, s};
    endfunction

    // Stand-in core: load restarts it, busy stays high for lat cycles.
    logic [127:0] mc_res = '0;
    logic         mc_busy = 1'b0;
    int           mc_cnt = 0;
    int           lat = 6;
    logic         force_busy = 1'b0;
    always @(posedge clk) begin
        if (core_load_o) begin
            mc_res  <= model(core_key_o, core_data_o, core_size_o, core_dec_o);
            mc_busy <= 1'b1;
            mc_cnt  <= lat - 1;
        end else if (mc_busy) begin
            if (mc_cnt == 0) mc_busy <= 1'b0;
            else mc_cnt <= mc_cnt - 1;
        end
    end
    assign core_busy_i = mc_busy | force_busy;
    assign core_data_i = mc_res;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    typedef struct {
        int           idx;
        logic [255:0] key;
        logic [127:0] data;
        logic [1:0]   size;
        logic         dec;
        logic [127:0] res;
        logic         err;
    } txn_t;
    txn_t ack_q[$];
    txn_t done_q[$];
    txn_t ma, md;

    task automatic expect_txn(input int idx, input logic [255:0] k, input logic [127:0] d,
                              input logic [1:0] s, input logic dec, input logic [127:0] res,
                              input logic err, input bit with_done);
        txn_t t;
        t = '{idx, k, d, s, dec, res, err};
        ack_q.push_back(t);
        if (with_done) done_q.push_back(t);
    endtask

    task automatic set_ops(input int idx, input logic [255:0] k, input logic [127:0] d,
                           input logic [1:0] s, input logic dec);
        req_key_i[idx*256 +: 256] = k;
        req_data_i[idx*128 +: 128] = d;
        req_size_i[idx*2 +: 2]     = s;
        req_dec_i[idx]             = dec;
    endtask

    always @(negedge clk) begin
        if (ack_o != '0) begin
            if (ack_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ack: got %b required none", ack_o);
            end else begin
                ma = ack_q.pop_front();
                chk("ack_onehot", 256'(ack_o), 256'(1) << ma.idx);
                chk("ack_grant_idx", 256'(grant_idx_o), 256'(ma.idx));
                chk("ack_load", 256'(core_load_o), 256'(1));
                chk("core_key", core_key_o, ma.key);
                chk("core_data", 256'(core_data_o), 256'(ma.data));
                chk("core_size_dec", 256'({core_size_o, core_dec_o}), 256'({ma.size, ma.dec}));
            end
        end
        if (done_o != '0) begin
            if (done_q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_done: got %b required none", done_o);
            end else begin
                md = done_q.pop_front();
                chk("done_onehot", 256'(done_o), 256'(1) << md.idx);
                chk("done_data", 256'(data_o), 256'(md.res));
                chk("done_err", 256'(err_o), 256'(md.err));
            end
        end else if (err_o) begin
            chk("err_without_done", 256'(err_o), 256'(0));
        end
    end

    task automatic wait_ack(output int who);
        who = -1;
        for (int k = 0; k < 40 && who < 0; k++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) if (ack_o[j]) who = j;
        end
        if (who < 0) bound_fail("ack_wait");
    endtask

    task automatic wait_done(input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (done_o[idx]) ok = 1'b1;
        end
        if (!ok) bound_fail("done_wait");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 256'(ack_o), 256'(0));
        chk({tag, "_done"}, 256'(done_o), 256'(0));
        chk({tag, "_data"}, 256'(data_o), 256'(0));
        chk({tag, "_err_busy_load"}, 256'({err_o, busy_o, core_load_o}), 256'(0));
        chk({tag, "_grant"}, 256'(grant_idx_o), 256'(0));
        chk({tag, "_core_key"}, core_key_o, 256'(0));
        chk({tag, "_core_ops"}, 256'({core_data_o, core_size_o, core_dec_o}), 256'(0));
    endtask

    task automatic run_one(input int idx, input logic [255:0] k, input logic [127:0] d,
                           input logic [1:0] s, input logic dec, input logic [127:0] res);
        int who;
        bit ok;
        @(negedge clk);
        set_ops(idx, k, d, s, dec);
        expect_txn(idx, k, d, s, dec, res, 1'b0, 1'b1);
        req_i[idx] = 1'b1;
        wait_ack(who);
        if (who >= 0) begin
            req_i[who] = 1'b0;
            set_ops(who, {8{$urandom}}, {4{$urandom}}, 2'($urandom), 1'($urandom));
            @(negedge clk);
            chk("ack_single_cycle", 256'({ack_o, core_load_o}), 256'(0));
            chk("busy_in_flight", 256'(busy_o), 256'(1));
            wait_done(idx, ok);
            if (ok) begin
                @(negedge clk);
                chk("done_single_cycle", 256'(done_o), 256'(0));
                chk("data_held", 256'(data_o), 256'(res));
            end
        end
    endtask

    typedef struct {
        int           idx;
        logic [255:0] key;
        logic [127:0] data;
        logic [1:0]   size;
        logic         dec;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[6];

    int rr_order[5] = '{0, 1, 2, 3, 0};
    int pt_order[2] = '{3, 0};

    initial begin
        int who, t0;
        bit ok;
        tbl[0] = '{0, {K128, 128'h0}, PT, 2'd0, 1'b0, CT};
        tbl[1] = '{2, {K128, 128'h0}, CT, 2'd0, 1'b1, PT};
        tbl[2] = '{1, {128'hdeadbeef_01234567_89abcdef_f00dcafe, 128'h55aa55aa_0f0f0f0f_12345678_9abcdef0},
                   128'hffeeddcc_bbaa9988_77665544_33221100, 2'd2, 1'b0, 128'h0};
        tbl[3] = '{3, {128'h11111111_22222222_33333333_44444444, 128'hcafef00d_0badc0de_a5a5a5a5_5a5a5a5a},
                   128'h0123456789abcdef0123456789abcdef, 2'd1, 1'b1, 128'h0};
        tbl[4] = '{0, {K128, 128'h0}, PT, 2'd0, 1'b1, 128'h0};
        tbl[5] = '{2, {256{1'b1}}, 128'h0, 2'd2, 1'b1, 128'h0};
        for (int i = 2; i < 6; i++)
            tbl[i].exp = model(tbl[i].key, tbl[i].data, tbl[i].size, tbl[i].dec);

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_one(tbl[i].idx, tbl[i].key, tbl[i].data, tbl[i].size, tbl[i].dec, tbl[i].exp);

        // All four requesters pending straight out of reset.
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < N; j++)
            set_ops(j, {8{32'(j * 16'h1111 + 7)}}, {4{32'(j + 1)}}, 2'(j % 3), 1'(j & 1));
        for (int n = 0; n < 5; n++)
            expect_txn(rr_order[n], {8{32'(rr_order[n] * 16'h1111 + 7)}}, {4{32'(rr_order[n] + 1)}},
                       2'(rr_order[n] % 3), 1'(rr_order[n] & 1),
                       model({8{32'(rr_order[n] * 16'h1111 + 7)}}, {4{32'(rr_order[n] + 1)}},
                             2'(rr_order[n] % 3), 1'(rr_order[n] & 1)), 1'b0, 1'b1);
        req_i = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wait_ack(who);
            chk("rr_order", 256'(who), 256'(rr_order[n]));
            if (who >= 0) begin
                req_i[who] = 1'b0;
                wait_done(who, ok);
                if (n < 4) req_i[who] = 1'b1;
            end
        end
        req_i = '0;

        // Serve requester 2 so the pointer sits at 3, then contend 3 against 0.
        run_one(2, {8{32'h2468ace0}}, {4{32'h13579bdf}}, 2'd1, 1'b0,
                model({8{32'h2468ace0}}, {4{32'h13579bdf}}, 2'd1, 1'b0));
        @(negedge clk);
        set_ops(0, {8{32'haaaa0000}}, {4{32'h0000aaaa}}, 2'd0, 1'b0);
        set_ops(3, {8{32'h3333cccc}}, {4{32'hcccc3333}}, 2'd2, 1'b1);
        for (int n = 0; n < 2; n++)
            expect_txn(pt_order[n], {8{pt_order[n] == 0 ? 32'haaaa0000 : 32'h3333cccc}},
                       {4{pt_order[n] == 0 ? 32'h0000aaaa : 32'hcccc3333}},
                       pt_order[n] == 0 ? 2'd0 : 2'd2, pt_order[n] == 3,
                       model({8{pt_order[n] == 0 ? 32'haaaa0000 : 32'h3333cccc}},
                             {4{pt_order[n] == 0 ? 32'h0000aaaa : 32'hcccc3333}},
                             pt_order[n] == 0 ? 2'd0 : 2'd2, pt_order[n] == 3), 1'b0, 1'b1);
        req_i = 4'b1001;
        for (int n = 0; n < 2; n++) begin
            wait_ack(who);
            chk("ptr_order", 256'(who), 256'(pt_order[n]));
            if (who >= 0) begin
                req_i[who] = 1'b0;
                wait_done(who, ok);
            end
        end

        // Continuous request with a one-cycle core: grants every 5 cycles.
        lat = 1;
        @(negedge clk);
        set_ops(3, {8{32'h0badf00d}}, {4{32'h600dcafe}}, 2'd0, 1'b0);
        repeat (2) expect_txn(3, {8{32'h0badf00d}}, {4{32'h600dcafe}}, 2'd0, 1'b0,
                              model({8{32'h0badf00d}}, {4{32'h600dcafe}}, 2'd0, 1'b0), 1'b0, 1'b1);
        req_i[3] = 1'b1;
        wait_ack(who);
        t0 = cyc;
        wait_ack(who);
        req_i[3] = 1'b0;
        chk("grant_period", 256'(cyc - t0), 256'(5));
        wait_done(3, ok);
        lat = 6;

        // Reset while RUN is waiting: no done, outputs cleared, requester 1 served afterwards.
        @(negedge clk);
        set_ops(1, {8{32'h01010101}}, {4{32'h10101010}}, 2'd0, 1'b0);
        expect_txn(1, {8{32'h01010101}}, {4{32'h10101010}}, 2'd0, 1'b0, 128'h0, 1'b0, 1'b0);
        req_i = 4'b0010;
        wait_ack(who);
        req_i = '0;
        repeat (2) @(negedge clk);
        chk("run_busy", 256'({busy_o, done_o}), 256'({1'b1, 4'b0000}));
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_one(1, {8{32'h01010101}}, {4{32'h10101010}}, 2'd0, 1'b0,
                model({8{32'h01010101}}, {4{32'h10101010}}, 2'd0, 1'b0));

`ifdef AES_ARB_TIMEOUT_EN
        force_busy = 1'b1;
        @(negedge clk);
        set_ops(1, {8{32'h77777777}}, {4{32'h88888888}}, 2'd2, 1'b0);
        expect_txn(1, {8{32'h77777777}}, {4{32'h88888888}}, 2'd2, 1'b0, 128'h0, 1'b1, 1'b1);
        req_i[1] = 1'b1;
        wait_ack(who);
        t0 = cyc;
        req_i[1] = 1'b0;
        wait_done(1, ok);
        chk("timeout_latency", 256'(cyc - t0), 256'(10));
        force_busy = 1'b0;
        @(negedge clk);
        chk("timeout_err_pulse", 256'({err_o, done_o}), 256'(0));
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 256'(ack_q.size() + done_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "bound expired");
    end
endmodule
